// File: rtl/flappy_pkg.sv
// Shared score/display definitions: widths, 7-segment and anode codes,
// and the converter state type.
package flappy_pkg;

   localparam int SCORE_W    = 10;
   localparam int NUM_DIGITS = 4;
   localparam int BCD_W      = 4 * NUM_DIGITS;

   // Cathodes are active-low, ordered {g,f,e,d,c,b,a}.
   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   localparam logic [3:0] AN_DIG0 = 4'b1110;
   localparam logic [3:0] AN_DIG1 = 4'b1101;
   localparam logic [3:0] AN_DIG2 = 4'b1011;
   localparam logic [3:0] AN_DIG3 = 4'b0111;

   typedef enum logic [1:0] {
      CONV_IDLE,
      CONV_SHIFT,
      CONV_COMMIT
   } conv_state_t;

   function automatic logic [6:0] seg_encode(input logic [3:0] nib);
      logic [6:0] code;
      case (nib)
         4'd0:    code = SEG_0;
         4'd1:    code = SEG_1;
         4'd2:    code = SEG_2;
         4'd3:    code = SEG_3;
         4'd4:    code = SEG_4;
         4'd5:    code = SEG_5;
         4'd6:    code = SEG_6;
         4'd7:    code = SEG_7;
         4'd8:    code = SEG_8;
         4'd9:    code = SEG_9;
         default: code = SEG_BLANK;
      endcase
      return code;
   endfunction

   function automatic logic [3:0] an_pattern(input logic [1:0] idx);
      logic [3:0] pat;
      case (idx)
         2'd0:    pat = AN_DIG0;
         2'd1:    pat = AN_DIG1;
         2'd2:    pat = AN_DIG2;
         default: pat = AN_DIG3;
      endcase
      return pat;
   endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Multi-cycle double-dabble converter: one add-3/shift step per clock,
// result committed to bcd with a single-cycle done pulse.
module bin2bcd_seq
   import flappy_pkg::*;
(
   input  logic               clk,
   input  logic               clr,
   input  logic               start,
   input  logic [SCORE_W-1:0] bin,
   output logic [BCD_W-1:0]   bcd,
   output logic               done,
   output logic               busy
);

   // state       | meaning
   // CONV_IDLE   | waiting for start; captures bin when start is high
   // CONV_SHIFT  | one add-3 + shift-left step per cycle, SCORE_W steps
   // CONV_COMMIT | copy BCD field to bcd and pulse done

   localparam int SR_W = BCD_W + SCORE_W;

   conv_state_t       state, state_next;
   logic [SR_W-1:0]   sr, sr_next;
   logic [3:0]        cnt, cnt_next;
   logic [BCD_W-1:0]  bcd_next;
   logic              done_next;

   function automatic logic [SR_W-1:0] dabble_step(input logic [SR_W-1:0] v);
      logic [SR_W-1:0] adj;
      adj = v;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (adj[SCORE_W + 4*k +: 4] >= 4'd5)
            adj[SCORE_W + 4*k +: 4] = adj[SCORE_W + 4*k +: 4] + 4'd3;
      end
      return {adj[SR_W-2:0], 1'b0};
   endfunction

   always_ff @(posedge clk) begin
      if (clr) begin
         state <= CONV_IDLE;
         sr    <= '0;
         cnt   <= '0;
         bcd   <= '0;
         done  <= 1'b0;
      end else begin
         state <= state_next;
         sr    <= sr_next;
         cnt   <= cnt_next;
         bcd   <= bcd_next;
         done  <= done_next;
      end
   end

   always_comb begin
      state_next = state;
      sr_next    = sr;
      cnt_next   = cnt;
      bcd_next   = bcd;
      done_next  = 1'b0;
      case (state)
         CONV_IDLE: begin
            if (start) begin
               sr_next    = {{BCD_W{1'b0}}, bin};
               cnt_next   = '0;
               state_next = CONV_SHIFT;
            end
         end
         CONV_SHIFT: begin
            sr_next = dabble_step(sr);
            if (cnt == 4'(SCORE_W - 1))
               state_next = CONV_COMMIT;
            else
               cnt_next = cnt + 4'd1;
         end
         CONV_COMMIT: begin
            bcd_next   = sr[SR_W-1:SCORE_W];
            done_next  = 1'b1;
            state_next = CONV_IDLE;
         end
         default: state_next = CONV_IDLE;
      endcase
   end

   assign busy = (state != CONV_IDLE);

endmodule

// File: rtl/score_display.sv
// Score formatter: picks current/highest score, converts on change, and
// scans the four BCD digits onto a common-anode 7-segment display.
module score_display
   import flappy_pkg::*;
#(
   parameter int REFRESH_DIV = 100000,
   parameter int BLANK_LZ    = 1
)(
   input  logic               clk,
   input  logic               clr,
   input  logic [SCORE_W-1:0] current_score,
   input  logic [SCORE_W-1:0] highest_score,
   input  logic               show_high,
   output logic [BCD_W-1:0]   bcd,
   output logic               done,
   output logic               busy,
   output logic [6:0]         seg,
   output logic [3:0]         an,
   output logic               dp
);

   localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

   logic [SCORE_W-1:0] src, last;
   logic               start;
   logic [CNT_W-1:0]   refresh_cnt;
   logic [1:0]         digit_idx, digit_next;
   logic               wrap;
   logic [3:0]         nib_next;
   logic               blank_next;
   logic [6:0]         seg_next;

   assign src   = show_high ? highest_score : current_score;
   // Source changes while the engine is busy are picked up on its return to idle.
   assign start = !busy && (src != last);

   always_ff @(posedge clk) begin
      if (clr)
         last <= '0;
      else if (start)
         last <= src;
   end

   bin2bcd_seq u_conv (
      .clk   (clk),
      .clr   (clr),
      .start (start),
      .bin   (src),
      .bcd   (bcd),
      .done  (done),
      .busy  (busy)
   );

   assign wrap       = (refresh_cnt == CNT_W'(REFRESH_DIV - 1));
   assign digit_next = digit_idx + 2'd1;

   always_comb begin
      nib_next   = bcd[{digit_next, 2'b00} +: 4];
      blank_next = 1'b0;
      if (BLANK_LZ != 0) begin
         case (digit_next)
            2'd1:    blank_next = (bcd[15:4]  == 12'd0);
            2'd2:    blank_next = (bcd[15:8]  == 8'd0);
            2'd3:    blank_next = (bcd[15:12] == 4'd0);
            default: blank_next = 1'b0;
         endcase
      end
      seg_next = blank_next ? SEG_BLANK : seg_encode(nib_next);
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         refresh_cnt <= '0;
         digit_idx   <= 2'd0;
         an          <= AN_DIG0;
         seg         <= SEG_0;
      end else if (wrap) begin
         refresh_cnt <= '0;
         digit_idx   <= digit_next;
         an          <= an_pattern(digit_next);
         seg         <= seg_next;
      end else begin
         refresh_cnt <= refresh_cnt + CNT_W'(1);
      end
   end

   assign dp = 1'b1;

endmodule

// File: tb/tb_score_display.sv
// Bench for score_display: decimal-arithmetic reference model checked every
// cycle, plus directed scenarios with literal expected values.
module tb_score_display;

   localparam int DIV = 4;

   logic        clk = 1'b0;
   logic        clr = 1'b1;
   logic [9:0]  current_score = '0;
   logic [9:0]  highest_score = '0;
   logic        show_high = 1'b0;
   logic [15:0] bcd;
   logic        done, busy, dp;
   logic [6:0]  seg;
   logic [3:0]  an;

   int checks   = 0;
   int failures = 0;

   score_display #(.REFRESH_DIV(DIV), .BLANK_LZ(1)) dut (
      .clk           (clk),
      .clr           (clr),
      .current_score (current_score),
      .highest_score (highest_score),
      .show_high     (show_high),
      .bcd           (bcd),
      .done          (done),
      .busy          (busy),
      .seg           (seg),
      .an            (an),
      .dp            (dp)
   );

   always #5 clk = ~clk;

   logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                7'b0000000, 7'b0010000};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] bcd_of(input int v);
      return 16'(((v / 1000) % 10) * 4096 + ((v / 100) % 10) * 256 +
                 ((v / 10) % 10) * 16 + (v % 10));
   endfunction

   function automatic logic [6:0] seg_of(input int v, input int k);
      int p;
      p = 10 ** k;
      if (k > 0 && v < p) return 7'b1111111;
      return seg_tab[(v / p) % 10];
   endfunction

   // Reference model: a conversion is a captured value plus an age in cycles;
   // the display value is a plain integer and digits come from division.
   bit         m_valid = 1'b0;
   int         m_last, m_val, m_cap, m_age, m_t;
   bit         m_conv, m_done;
   logic [3:0] m_an;
   logic [6:0] m_seg;

   always @(posedge clk) begin : model
      int src_v;
      int old_val;
      int idx;
      src_v = show_high ? int'(highest_score) : int'(current_score);
      if (clr) begin
         m_valid = 1'b1;
         m_last  = 0;
         m_val   = 0;
         m_conv  = 1'b0;
         m_done  = 1'b0;
         m_age   = 0;
         m_t     = 0;
         m_an    = 4'b1110;
         m_seg   = seg_of(0, 0);
      end else if (m_valid) begin
         old_val = m_val;
         m_done  = 1'b0;
         if (m_conv) begin
            m_age++;
            if (m_age == 11) begin
               m_val  = m_cap;
               m_done = 1'b1;
               m_conv = 1'b0;
            end
         end else if (src_v != m_last) begin
            m_conv = 1'b1;
            m_age  = 0;
            m_cap  = src_v;
            m_last = src_v;
         end
         m_t++;
         if (m_t % DIV == 0) begin
            idx   = (m_t / DIV) % 4;
            m_an  = ~(4'b0001 << idx);
            m_seg = seg_of(old_val, idx);
         end
      end
      #1;
      if (m_valid) begin
         check("model_bcd",  {16'd0, bcd},  {16'd0, bcd_of(m_val)});
         check("model_done", {31'd0, done}, {31'd0, m_done});
         check("model_busy", {31'd0, busy}, {31'd0, m_conv});
         check("model_an",   {28'd0, an},   {28'd0, m_an});
         check("model_seg",  {25'd0, seg},  {25'd0, m_seg});
         check("model_dp",   {31'd0, dp},   32'd1);
      end
   end

   task automatic wait_done(input int max_cycles, output int n);
      n = 0;
      for (int i = 1; i <= max_cycles; i++) begin
         @(posedge clk); #1;
         if (done) begin
            n = i;
            break;
         end
      end
   endtask

   initial begin : stim
      int n, first, second;
      logic [3:0] seen;

      clr = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_an",   {28'd0, an},   32'b1110);
      check("rst_seg",  {25'd0, seg},  32'b1000000);
      check("rst_bcd",  {16'd0, bcd},  32'h0000);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      @(negedge clk) clr = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check("idle_zero_busy", {31'd0, busy}, 32'd0);

      @(negedge clk) current_score = 10'd37;
      wait_done(30, n);
      check("lat_37", n, 12);
      check("bcd_37", {16'd0, bcd}, 32'h0037);
      @(posedge clk); #1;
      check("done_37_drop", {31'd0, done}, 32'd0);

      @(negedge clk);
      highest_score = 10'd1023;
      show_high     = 1'b1;
      wait_done(30, n);
      check("lat_1023", n, 12);
      check("bcd_1023", {16'd0, bcd}, 32'h1023);
      repeat (DIV) @(posedge clk);
      seen = '0;
      for (int i = 0; i < 16; i++) begin
         @(posedge clk); #1;
         seen |= ~an;
         case (an)
            4'b1110: check("scan_1023_d0", {25'd0, seg}, 32'b0110000);
            4'b1101: check("scan_1023_d1", {25'd0, seg}, 32'b0100100);
            4'b1011: check("scan_1023_d2", {25'd0, seg}, 32'b1000000);
            4'b0111: check("scan_1023_d3", {25'd0, seg}, 32'b1111001);
            default: check("scan_1023_an", {28'd0, an}, 32'b1110);
         endcase
      end
      check("scan_1023_all_anodes", {28'd0, seen}, 32'hF);

      @(negedge clk);
      show_high     = 1'b0;
      current_score = 10'd7;
      wait_done(30, n);
      check("lat_7", n, 12);
      check("bcd_7", {16'd0, bcd}, 32'h0007);
      repeat (DIV) @(posedge clk);
      seen = '0;
      for (int i = 0; i < 16; i++) begin
         @(posedge clk); #1;
         seen |= ~an;
         if (an == 4'b1110) check("blank_7_d0", {25'd0, seg}, 32'b1111000);
         else               check("blank_7_dk", {25'd0, seg}, 32'b1111111);
      end
      check("blank_7_all_anodes", {28'd0, seen}, 32'hF);

      @(negedge clk) current_score = 10'd5;
      first  = 0;
      second = 0;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk); #1;
         if (done) begin
            if (first == 0) begin
               first = i;
               check("bcd_5_first", {16'd0, bcd}, 32'h0005);
            end else if (second == 0) begin
               second = i;
               check("bcd_9_second", {16'd0, bcd}, 32'h0009);
            end
         end
         if (i == 3) begin
            @(negedge clk) current_score = 10'd9;
         end
      end
      check("lat_5_first", first, 12);
      check("lat_9_second", second, 24);

      @(negedge clk) current_score = 10'd512;
      for (int i = 1; i <= 5; i++) begin
         @(posedge clk); #1;
         check("abort_no_done", {31'd0, done}, 32'd0);
      end
      @(negedge clk) clr = 1'b1;
      @(posedge clk); #1;
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_bcd",  {16'd0, bcd},  32'h0000);
      check("abort_done", {31'd0, done}, 32'd0);
      @(negedge clk) clr = 1'b0;
      wait_done(30, n);
      check("lat_512", n, 12);
      check("bcd_512", {16'd0, bcd}, 32'h0512);

      repeat (5) @(posedge clk);
      #2;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin : watchdog
      #200000;
      failures++;
      $display("FAIL watchdog actual=running required=finished");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog expired");
   end

endmodule
